mem_lsu: RTL

- Parametrised load/store unit that replaces the single-cycle memory stage.
- Sits between the register manager (issue side) and writeback.
- Computes the effective address, checks alignment, drives a request/acknowledge memory port with byte strobes, aligns and sign- or zero-extends load data, and holds one result for writeback under a valid/ready handshake.
- Supports multi-cycle memory latency.

---
 rtl/mem_lsu_if.sv | 51 +++++
 rtl/mem_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
// Issue, memory-port and writeback signals of the load/store unit.
// master is the LSU side; slave is the surrounding pipeline and memory.
interface mem_lsu_if #(
  parameter int XLEN = 32
);
  localparam int STRB_W = XLEN / 8;

  logic              issue_valid;
  logic              issue_ready;
  logic              issue_store;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [XLEN-1:0]   immediate;
  logic [4:0]        rd_i;

  logic              mem_req_v;
  logic              mem_we;
  logic [XLEN-1:0]   mem_adr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_strobe;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_err;

  logic              wb_valid;
  logic              wb_ready;
  logic [XLEN-1:0]   wb_result;
  logic [4:0]        wb_rd;
  logic              wb_exc;
  logic [1:0]        wb_cause;

  modport master (
    input  issue_valid, issue_store, size, unsigned_ld, rs1, rs2, immediate, rd_i,
    output issue_ready,
    output mem_req_v, mem_we, mem_adr, mem_wdata, mem_strobe,
    input  mem_ack, mem_rdata, mem_err,
    output wb_valid, wb_result, wb_rd, wb_exc, wb_cause,
    input  wb_ready
  );

  modport slave (
    output issue_valid, issue_store, size, unsigned_ld, rs1, rs2, immediate, rd_i,
    input  issue_ready,
    input  mem_req_v, mem_we, mem_adr, mem_wdata, mem_strobe,
    output mem_ack, mem_rdata, mem_err,
    input  wb_valid, wb_result, wb_rd, wb_exc, wb_cause,
    output wb_ready
  );
endinterface

// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit: address/alignment check, strobed memory request, load extension, held writeback.
// Define MEM_LSU_TIMEOUT_EN to fault a request that waits TIMEOUT cycles without mem_ack.
module mem_lsu #(
  parameter int XLEN    = 32,
  parameter int STRB_W  = XLEN / 8,
  parameter int TIMEOUT = 64
) (
  input logic       clk,
  input logic       rst,
  mem_lsu_if.master bus
);
  localparam int OFF_W = $clog2(STRB_W);

  if ((XLEN != 32 && XLEN != 64) || TIMEOUT < 2) begin : g_param_check
    $error("mem_lsu: XLEN must be 32 or 64 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_v_q, mem_req_v_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_adr_q, mem_adr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_strobe_q, mem_strobe_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_exc_q, wb_exc_d;
  logic [1:0]        wb_cause_q, wb_cause_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_unsigned_q, ld_unsigned_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [OFF_W-1:0]  ld_off_q, ld_off_d;
`ifdef MEM_LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  logic              issue_ready;
  logic              accept;
  logic [XLEN-1:0]   ea;
  logic [OFF_W-1:0]  off;
  logic              misaligned;
  logic [STRB_W-1:0] strb_base;
  logic [XLEN-1:0]   ld_shifted;
  logic [XLEN-1:0]   ld_ext;
  logic              ld_sign;
  int unsigned       ext_w;

  assign issue_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.wb_ready);
  assign accept      = bus.issue_valid && issue_ready;
  assign ea          = bus.rs1 + bus.immediate;
  assign off         = ea[OFF_W-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (bus.size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = (XLEN == 32) ? 1'b1 : |off;
    endcase
    strb_base = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_base[i] = (i < (1 << bus.size));
    end
  end

  // Load data arrives word-aligned; bring the addressed lane down and extend above its width.
  always_comb begin
    ld_shifted = bus.mem_rdata >> {ld_off_q, 3'b000};
    ext_w      = 32'd8 << ld_size_q;
    case (ld_size_q)
      2'd0:    ld_sign = ld_shifted[7];
      2'd1:    ld_sign = ld_shifted[15];
      2'd2:    ld_sign = ld_shifted[31];
      default: ld_sign = ld_shifted[XLEN-1];
    endcase
    ld_sign = ld_sign && !ld_unsigned_q;
    ld_ext  = ld_shifted;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= ext_w) ld_ext[i] = ld_sign;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_v_d   = mem_req_v_q;
    mem_we_d      = mem_we_q;
    mem_adr_d     = mem_adr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_strobe_d  = mem_strobe_q;
    wb_valid_d    = wb_valid_q;
    wb_exc_d      = wb_exc_q;
    wb_cause_d    = wb_cause_q;
    wb_result_d   = wb_result_q;
    wb_rd_d       = wb_rd_q;
    ld_size_d     = ld_size_q;
    ld_unsigned_d = ld_unsigned_q;
    ld_rd_d       = ld_rd_q;
    ld_off_d      = ld_off_q;
`ifdef MEM_LSU_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif

    case (state_q)
      ST_WAIT: begin
        if (bus.mem_ack) begin
          state_d     = ST_DONE;
          mem_req_v_d = 1'b0;
          wb_valid_d  = 1'b1;
          if (bus.mem_err) begin
            wb_exc_d    = 1'b1;
            wb_cause_d  = 2'd2;
            wb_rd_d     = '0;
            wb_result_d = mem_adr_q;
          end else begin
            wb_exc_d    = 1'b0;
            wb_cause_d  = 2'd0;
            wb_rd_d     = mem_we_q ? 5'd0 : ld_rd_q;
            wb_result_d = mem_we_q ? '0 : ld_ext;
          end
        end
`ifdef MEM_LSU_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          mem_req_v_d = 1'b0;
          wb_valid_d  = 1'b1;
          wb_exc_d    = 1'b1;
          wb_cause_d  = 2'd3;
          wb_rd_d     = '0;
          wb_result_d = mem_adr_q;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (bus.wb_ready) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // An accept in DONE overrides the return to IDLE so back-to-back ops see no bubble.
    if (accept) begin
      if (misaligned) begin
        state_d     = ST_DONE;
        wb_valid_d  = 1'b1;
        wb_exc_d    = 1'b1;
        wb_cause_d  = 2'd1;
        wb_result_d = ea;
        wb_rd_d     = '0;
      end else begin
        state_d       = ST_WAIT;
        wb_valid_d    = 1'b0;
        mem_req_v_d   = 1'b1;
        mem_we_d      = bus.issue_store;
        mem_adr_d     = ea;
        mem_strobe_d  = strb_base << off;
        mem_wdata_d   = bus.rs2 << {off, 3'b000};
        ld_size_d     = bus.size;
        ld_unsigned_d = bus.unsigned_ld;
        ld_rd_d       = bus.rd_i;
        ld_off_d      = off;
`ifdef MEM_LSU_TIMEOUT_EN
        tmo_d         = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_v_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_adr_q     <= '0;
      mem_wdata_q   <= '0;
      mem_strobe_q  <= '0;
      wb_valid_q    <= 1'b0;
      wb_exc_q      <= 1'b0;
      wb_cause_q    <= '0;
      wb_result_q   <= '0;
      wb_rd_q       <= '0;
      ld_size_q     <= '0;
      ld_unsigned_q <= 1'b0;
      ld_rd_q       <= '0;
      ld_off_q      <= '0;
`ifdef MEM_LSU_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_v_q   <= mem_req_v_d;
      mem_we_q      <= mem_we_d;
      mem_adr_q     <= mem_adr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_strobe_q  <= mem_strobe_d;
      wb_valid_q    <= wb_valid_d;
      wb_exc_q      <= wb_exc_d;
      wb_cause_q    <= wb_cause_d;
      wb_result_q   <= wb_result_d;
      wb_rd_q       <= wb_rd_d;
      ld_size_q     <= ld_size_d;
      ld_unsigned_q <= ld_unsigned_d;
      ld_rd_q       <= ld_rd_d;
      ld_off_q      <= ld_off_d;
`ifdef MEM_LSU_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.mem_req_v   = mem_req_v_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_adr     = mem_adr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_strobe  = mem_strobe_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_exc      = wb_exc_q;
  assign bus.wb_cause    = wb_cause_q;
  assign bus.wb_result   = wb_result_q;
  assign bus.wb_rd       = wb_rd_q;
endmodule
